// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI-to-register-bus arbiter.
package spi_reg_pkg;

   localparam int SPI_ADRSIZE     = 8;
   localparam int SPI_DATASIZE    = 32;
   localparam int SPI_WR_FLAG_POS = SPI_ADRSIZE - 1;
   localparam logic [31:0] SPI_ERR_WORD = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPI_RD = 3'd1,
      ST_SPI_WR = 3'd2,
      ST_LOC    = 3'd3,
      ST_DONE   = 3'd4
   } arb_state_e;

endpackage

// File: rtl/spi_reg_arbiter_edge_sync.sv
// 3-flop synchroniser for an sclk-domain level, with a rising-edge pulse in the clock domain.
module edge_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic level,
   output logic rise
);

   logic [2:0] sync_r;
   logic [1:0] prime_r;

   // Shift the level through the chain; prime_r masks the edge seen while the chain refills after reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_r  <= 3'b000;
         prime_r <= 2'd0;
      end else begin
         sync_r <= {sync_r[1:0], level};
         if (prime_r != 2'd3) begin
            prime_r <= prime_r + 2'd1;
         end
      end
   end

   assign rise = sync_r[1] & ~sync_r[2] & (prime_r == 2'd3);

endmodule

// File: rtl/spi_reg_arbiter.sv
// Bridges SPI slave address/data events onto the register bus, sharing it with one local requester.
// Optional bus timeout: define SPI_REG_TIMEOUT_EN.
module spi_reg_arbiter
   import spi_reg_pkg::*;
#(
   parameter int                  ADRSIZE  = SPI_ADRSIZE,
   parameter int                  DATASIZE = SPI_DATASIZE,
   parameter int                  TIMEOUT  = 64,
   parameter logic [DATASIZE-1:0] ERR_WORD = DATASIZE'(SPI_ERR_WORD)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                spi_adr_latched,
   input  logic                spi_data_latched,
   input  logic [ADRSIZE-1:0]  spi_adr,
   input  logic [DATASIZE-1:0] spi_wdata,
   output logic [DATASIZE-1:0] spi_rdata,
   input  logic                loc_req,
   input  logic                loc_wr,
   input  logic [ADRSIZE-2:0]  loc_adr,
   input  logic [DATASIZE-1:0] loc_wdata,
   output logic [DATASIZE-1:0] loc_rdata,
   output logic                loc_ack,
   output logic [ADRSIZE-2:0]  reg_adr,
   output logic                reg_wr,
   output logic                reg_rd,
   output logic [DATASIZE-1:0] reg_wdata,
   input  logic [DATASIZE-1:0] reg_rdata,
   input  logic                reg_ack,
   output logic                busy,
   output logic                err
);

   localparam int RIDX   = ADRSIZE - 1;
   localparam int WR_BIT = (ADRSIZE == SPI_ADRSIZE) ? SPI_WR_FLAG_POS : ADRSIZE - 1;

   logic adr_rise_s;
   logic data_rise_s;

   edge_sync u_adr_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (spi_adr_latched),
      .rise    (adr_rise_s)
   );

   edge_sync u_data_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (spi_data_latched),
      .rise    (data_rise_s)
   );

   arb_state_e          state_r;
   logic                pend_rd_r;
   logic                pend_wr_r;
   logic [RIDX-1:0]     rd_adr_r;
   logic [RIDX-1:0]     wr_adr_r;
   logic [DATASIZE-1:0] wr_data_r;
   logic                loc_wr_r;
   logic                set_rd_s;
   logic                set_wr_s;
   logic                take_rd_s;
   logic                take_wr_s;
   logic                take_loc_s;

`ifdef SPI_REG_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   logic [TW-1:0] timer_r;
   logic          err_r;
   assign err = err_r;
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^{ERR_WORD, 32'(TIMEOUT)};
   assign err = 1'b0;
`endif

   // Qualify synchronised edges by the write flag and pick the next access in IDLE.
   always_comb begin
      set_rd_s   = adr_rise_s & ~spi_adr[WR_BIT];
      set_wr_s   = data_rise_s & spi_adr[WR_BIT];
      take_rd_s  = 1'b0;
      take_wr_s  = 1'b0;
      take_loc_s = 1'b0;
      if (state_r == ST_IDLE) begin
         take_rd_s  = pend_rd_r;
         take_wr_s  = ~pend_rd_r & pend_wr_r;
         take_loc_s = ~pend_rd_r & ~pend_wr_r & loc_req;
      end else begin
         take_rd_s  = 1'b0;
         take_wr_s  = 1'b0;
         take_loc_s = 1'b0;
      end
   end

   // Pending flags and sampled SPI address/data; a new event outranks the clear so the last frame wins.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pend_rd_r <= 1'b0;
         pend_wr_r <= 1'b0;
         rd_adr_r  <= {RIDX{1'b0}};
         wr_adr_r  <= {RIDX{1'b0}};
         wr_data_r <= {DATASIZE{1'b0}};
      end else begin
         if (set_rd_s) begin
            pend_rd_r <= 1'b1;
            rd_adr_r  <= spi_adr[RIDX-1:0];
         end else if (take_rd_s) begin
            pend_rd_r <= 1'b0;
         end
         if (set_wr_s) begin
            pend_wr_r <= 1'b1;
            wr_adr_r  <= spi_adr[RIDX-1:0];
            wr_data_r <= spi_wdata;
         end else if (take_wr_s) begin
            pend_wr_r <= 1'b0;
         end
      end
   end

   // Access FSM with registered bus strobes and completion outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         reg_adr   <= {RIDX{1'b0}};
         reg_wdata <= {DATASIZE{1'b0}};
         reg_rd    <= 1'b0;
         reg_wr    <= 1'b0;
         spi_rdata <= {DATASIZE{1'b0}};
         loc_rdata <= {DATASIZE{1'b0}};
         loc_ack   <= 1'b0;
         loc_wr_r  <= 1'b0;
         busy      <= 1'b0;
`ifdef SPI_REG_TIMEOUT_EN
         timer_r   <= {TW{1'b0}};
         err_r     <= 1'b0;
`endif
      end else begin
         loc_ack <= 1'b0;
         case (state_r)
            ST_IDLE: begin
`ifdef SPI_REG_TIMEOUT_EN
               timer_r <= {TW{1'b0}};
`endif
               if (take_rd_s) begin
                  state_r <= ST_SPI_RD;
                  reg_adr <= rd_adr_r;
                  reg_rd  <= 1'b1;
                  busy    <= 1'b1;
               end else if (take_wr_s) begin
                  state_r   <= ST_SPI_WR;
                  reg_adr   <= wr_adr_r;
                  reg_wdata <= wr_data_r;
                  reg_wr    <= 1'b1;
                  busy      <= 1'b1;
               end else if (take_loc_s) begin
                  state_r   <= ST_LOC;
                  reg_adr   <= loc_adr;
                  reg_wdata <= loc_wdata;
                  reg_rd    <= ~loc_wr;
                  reg_wr    <= loc_wr;
                  loc_wr_r  <= loc_wr;
                  busy      <= 1'b1;
               end
            end
            ST_SPI_RD, ST_SPI_WR, ST_LOC: begin
               if (reg_ack) begin
                  reg_rd  <= 1'b0;
                  reg_wr  <= 1'b0;
                  state_r <= ST_DONE;
                  if (state_r == ST_SPI_RD) begin
                     spi_rdata <= reg_rdata;
                  end
                  if (state_r == ST_LOC) begin
                     loc_ack <= 1'b1;
                     if (!loc_wr_r) begin
                        loc_rdata <= reg_rdata;
                     end
                  end
`ifdef SPI_REG_TIMEOUT_EN
               end else if (timer_r == TMAX) begin
                  reg_rd  <= 1'b0;
                  reg_wr  <= 1'b0;
                  err_r   <= 1'b1;
                  state_r <= ST_DONE;
                  if (state_r == ST_SPI_RD) begin
                     spi_rdata <= ERR_WORD;
                  end
                  if (state_r == ST_LOC) begin
                     loc_ack   <= 1'b1;
                     loc_rdata <= ERR_WORD;
                  end
               end else begin
                  timer_r <= timer_r + TW'(1);
`endif
               end
            end
            ST_DONE: begin
               // One strobe-free bus cycle between consecutive accesses.
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               reg_rd  <= 1'b0;
               reg_wr  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter; a timeout scenario runs when SPI_REG_TIMEOUT_EN is defined.
module tb_spi_reg_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_adr_latched = 1'b0;
   logic        spi_data_latched = 1'b0;
   logic [7:0]  spi_adr = 8'h00;
   logic [31:0] spi_wdata = 32'h0;
   logic [31:0] spi_rdata;
   logic        loc_req = 1'b0;
   logic        loc_wr = 1'b0;
   logic [6:0]  loc_adr = 7'h00;
   logic [31:0] loc_wdata = 32'h0;
   logic [31:0] loc_rdata;
   logic        loc_ack;
   logic [6:0]  reg_adr;
   logic        reg_wr;
   logic        reg_rd;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata = 32'h0;
   logic        reg_ack = 1'b0;
   logic        busy;
   logic        err;

   int total_cnt = 0;
   int pass_cnt  = 0;

   spi_reg_arbiter dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .spi_adr_latched  (spi_adr_latched),
      .spi_data_latched (spi_data_latched),
      .spi_adr          (spi_adr),
      .spi_wdata        (spi_wdata),
      .spi_rdata        (spi_rdata),
      .loc_req          (loc_req),
      .loc_wr           (loc_wr),
      .loc_adr          (loc_adr),
      .loc_wdata        (loc_wdata),
      .loc_rdata        (loc_rdata),
      .loc_ack          (loc_ack),
      .reg_adr          (reg_adr),
      .reg_wr           (reg_wr),
      .reg_rd           (reg_rd),
      .reg_wdata        (reg_wdata),
      .reg_rdata        (reg_rdata),
      .reg_ack          (reg_ack),
      .busy             (busy),
      .err              (err)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Advance until the requested strobe is high; n == budget means it never came.
   task automatic wait_strobe(input logic want_wr, input int budget, output int n);
      n = 0;
      while (((want_wr ? reg_wr : reg_rd) !== 1'b1) && (n < budget)) begin
         tick();
         n++;
      end
   endtask

   task automatic drop_flags;
      spi_adr_latched  = 1'b0;
      spi_data_latched = 1'b0;
      repeat (6) tick();
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if ({reg_rd, reg_wr, loc_ack, busy, err} !== 5'b00000) $display("FAIL reset_ctrl: got %b want 00000", {reg_rd, reg_wr, loc_ack, busy, err});
      else pass_cnt++;
      total_cnt++;
      if ({reg_adr, reg_wdata} !== 39'h0) $display("FAIL reset_bus: got %h want 0", {reg_adr, reg_wdata});
      else pass_cnt++;
      total_cnt++;
      if ({spi_rdata, loc_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {spi_rdata, loc_rdata});
      else pass_cnt++;
      reset_n = 1'b1;
      repeat (6) tick();
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_spi_read;
      int n;
      spi_adr = 8'h05;
      spi_adr_latched = 1'b1;
      wait_strobe(1'b0, 12, n);
      total_cnt++;
      if (n !== 4) $display("FAIL rd_latency: got %0d want 4", n);
      else pass_cnt++;
      total_cnt++;
      if ({reg_adr, reg_wr} !== {7'h05, 1'b0}) $display("FAIL rd_adr: got %h/%b want 05/0", reg_adr, reg_wr);
      else pass_cnt++;
      tick();
      reg_ack = 1'b1;
      reg_rdata = 32'hCAFE_0001;
      tick();
      reg_ack = 1'b0;
      total_cnt++;
      if ({reg_rd, busy} !== 2'b01) $display("FAIL rd_release: got %b want 01", {reg_rd, busy});
      else pass_cnt++;
      total_cnt++;
      if (spi_rdata !== 32'hCAFE_0001) $display("FAIL rd_data: got %h want cafe0001", spi_rdata);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL rd_done: busy got %b want 0", busy);
      else pass_cnt++;
      drop_flags();
   endtask

   task automatic test_spi_write;
      int n;
      int strobes;
      logic seen;
      spi_adr = 8'h83;
      spi_adr_latched = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (reg_rd || reg_wr) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL wr_no_adr_access: got %b want 0", seen);
      else pass_cnt++;
      spi_wdata = 32'h1234_5678;
      spi_data_latched = 1'b1;
      wait_strobe(1'b1, 12, n);
      total_cnt++;
      if (n !== 4) $display("FAIL wr_latency: got %0d want 4", n);
      else pass_cnt++;
      total_cnt++;
      if ({reg_adr, reg_wdata, reg_rd} !== {7'h03, 32'h1234_5678, 1'b0}) $display("FAIL wr_bus: got %h %h %b want 03 12345678 0", reg_adr, reg_wdata, reg_rd);
      else pass_cnt++;
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      strobes = 0;
      repeat (10) begin
         if (reg_wr || reg_rd) strobes++;
         tick();
      end
      total_cnt++;
      if (strobes !== 0) $display("FAIL wr_single: extra strobe cycles got %0d want 0", strobes);
      else pass_cnt++;
      drop_flags();
   endtask

   task automatic test_contention;
      int acks;
      spi_adr = 8'h07;
      spi_adr_latched = 1'b1;
      repeat (3) tick();
      loc_req = 1'b1;
      loc_wr  = 1'b0;
      loc_adr = 7'h10;
      tick();
      total_cnt++;
      if ({reg_rd, reg_adr} !== {1'b1, 7'h07}) $display("FAIL cont_spi_first: got %b/%h want 1/07", reg_rd, reg_adr);
      else pass_cnt++;
      reg_ack = 1'b1;
      reg_rdata = 32'h0000_0077;
      tick();
      reg_ack = 1'b0;
      total_cnt++;
      if ({spi_rdata, loc_ack} !== {32'h0000_0077, 1'b0}) $display("FAIL cont_spi_data: got %h/%b want 00000077/0", spi_rdata, loc_ack);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({reg_rd, reg_wr, busy} !== 3'b000) $display("FAIL cont_gap: got %b want 000", {reg_rd, reg_wr, busy});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({reg_rd, reg_adr} !== {1'b1, 7'h10}) $display("FAIL cont_loc: got %b/%h want 1/10", reg_rd, reg_adr);
      else pass_cnt++;
      reg_ack = 1'b1;
      reg_rdata = 32'hA5A5_0010;
      tick();
      reg_ack = 1'b0;
      loc_req = 1'b0;
      total_cnt++;
      if ({loc_ack, loc_rdata} !== {1'b1, 32'hA5A5_0010}) $display("FAIL cont_loc_ack: got %b/%h want 1/a5a50010", loc_ack, loc_rdata);
      else pass_cnt++;
      acks = 0;
      repeat (6) begin
         tick();
         if (loc_ack) acks++;
      end
      total_cnt++;
      if ({acks, spi_rdata} !== {32'd0, 32'h0000_0077}) $display("FAIL cont_single_ack: got %0d/%h want 0/00000077", acks, spi_rdata);
      else pass_cnt++;
      drop_flags();
   endtask

   task automatic test_spi_during_local;
      int n;
      loc_req   = 1'b1;
      loc_wr    = 1'b1;
      loc_adr   = 7'h22;
      loc_wdata = 32'h0BAD_F00D;
      wait_strobe(1'b1, 8, n);
      total_cnt++;
      if ({reg_wr, reg_adr, reg_wdata} !== {1'b1, 7'h22, 32'h0BAD_F00D}) $display("FAIL mix_loc_wr: got %b %h %h want 1 22 0badf00d", reg_wr, reg_adr, reg_wdata);
      else pass_cnt++;
      spi_adr   = 8'h81;
      spi_wdata = 32'h5555_AAAA;
      spi_adr_latched  = 1'b1;
      spi_data_latched = 1'b1;
      repeat (6) tick();
      total_cnt++;
      if ({reg_wr, reg_adr, reg_wdata} !== {1'b1, 7'h22, 32'h0BAD_F00D}) $display("FAIL mix_no_preempt: got %b %h %h want 1 22 0badf00d", reg_wr, reg_adr, reg_wdata);
      else pass_cnt++;
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      loc_req = 1'b0;
      total_cnt++;
      if ({loc_ack, reg_wr, loc_rdata} !== {1'b1, 1'b0, 32'hA5A5_0010}) $display("FAIL mix_loc_done: got %b %b %h want 1 0 a5a50010", loc_ack, reg_wr, loc_rdata);
      else pass_cnt++;
      repeat (2) tick();
      total_cnt++;
      if ({reg_wr, reg_adr, reg_wdata} !== {1'b1, 7'h01, 32'h5555_AAAA}) $display("FAIL mix_spi_wr: got %b %h %h want 1 01 5555aaaa", reg_wr, reg_adr, reg_wdata);
      else pass_cnt++;
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      total_cnt++;
      if ({reg_wr, loc_ack} !== 2'b00) $display("FAIL mix_spi_done: got %b want 00", {reg_wr, loc_ack});
      else pass_cnt++;
      drop_flags();
   endtask

   task automatic test_reset_mid;
      int n;
      logic activity;
      spi_adr   = 8'h84;
      spi_wdata = 32'hFEED_0004;
      spi_adr_latched  = 1'b1;
      spi_data_latched = 1'b1;
      wait_strobe(1'b1, 12, n);
      total_cnt++;
      if ({reg_wr, reg_adr, reg_wdata} !== {1'b1, 7'h04, 32'hFEED_0004}) $display("FAIL rst_mid_setup: got %b %h %h want 1 04 feed0004", reg_wr, reg_adr, reg_wdata);
      else pass_cnt++;
      reset_n = 1'b0;
      tick();
      total_cnt++;
      if ({reg_wr, reg_rd, busy, loc_ack, reg_adr, reg_wdata, spi_rdata} !== 75'h0) $display("FAIL rst_mid_outputs: got %b%b%b%b %h %h %h want all 0", reg_wr, reg_rd, busy, loc_ack, reg_adr, reg_wdata, spi_rdata);
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      activity = 1'b0;
      repeat (15) begin
         tick();
         if (reg_rd || reg_wr || busy) activity = 1'b1;
      end
      total_cnt++;
      if (activity !== 1'b0) $display("FAIL rst_mid_quiet: got %b want 0", activity);
      else pass_cnt++;
      drop_flags();
      spi_adr = 8'h02;
      spi_adr_latched = 1'b1;
      wait_strobe(1'b0, 12, n);
      total_cnt++;
      if ({n, reg_adr} !== {32'd4, 7'h02}) $display("FAIL rst_mid_rearm: got %0d/%h want 4/02", n, reg_adr);
      else pass_cnt++;
      reg_ack = 1'b1;
      reg_rdata = 32'h0202_0202;
      tick();
      reg_ack = 1'b0;
      total_cnt++;
      if (spi_rdata !== 32'h0202_0202) $display("FAIL rst_mid_data: got %h want 02020202", spi_rdata);
      else pass_cnt++;
      tick();
      drop_flags();
   endtask

   task automatic test_err;
`ifdef SPI_REG_TIMEOUT_EN
      int n;
      spi_adr = 8'h09;
      spi_adr_latched = 1'b1;
      wait_strobe(1'b0, 12, n);
      total_cnt++;
      if ({reg_rd, err} !== 2'b10) $display("FAIL to_start: got %b want 10", {reg_rd, err});
      else pass_cnt++;
      n = 0;
      while ((reg_rd === 1'b1) && (n < 200)) begin
         tick();
         n++;
      end
      total_cnt++;
      if (n !== 64) $display("FAIL to_cycles: got %0d want 64", n);
      else pass_cnt++;
      total_cnt++;
      if ({err, spi_rdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL to_result: got %b/%h want 1/deadbeef", err, spi_rdata);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({busy, err} !== 2'b01) $display("FAIL to_sticky: got %b want 01", {busy, err});
      else pass_cnt++;
      drop_flags();
`else
      total_cnt++;
      if (err !== 1'b0) $display("FAIL err_tied: got %b want 0", err);
      else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_spi_read();
      test_spi_write();
      test_contention();
      test_spi_during_local();
      test_reset_mid();
      test_err();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/spi_reg_arbiter.md
Name: spi_reg_arbiter

Overview:
- Sits between the SPI slave (sclk domain) and the on-chip register bus (system clock domain).
- Converts the slave's address-latched and data-latched flags into register reads and writes:
  - a read result is returned to the slave's parallel data input before shift-out;
  - a write is issued after the last bit arrives.
- Also shares the register bus with one local requester (on-chip sequencer), with SPI at fixed priority.

Parameters:
- ADRSIZE, 8, SPI address width; MSB is the write flag (1=write, 0=read), the remaining bits are the register index.
- DATASIZE, 32, register data width.
- TIMEOUT, 64, bus cycles to wait for reg_ack before abort (used only with the optional feature).
- ERR_WORD, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clock  in  1  system clock; must be at least 8x sclk.
- reset_n  in  1  synchronous active-low reset.
- spi_adr_latched  in  1  sclk-domain level from the SPI slave; rises when the address is complete.
- spi_data_latched  in  1  sclk-domain level; rises when the data word is complete.
- spi_adr  in  ADRSIZE  address from the slave; stable while spi_adr_latched is high.
- spi_wdata  in  DATASIZE  write data from the slave; stable while spi_data_latched is high.
- spi_rdata  out  DATASIZE  read data to the slave's parallel input; held until the next read.
- loc_req  in  1  local request; level, held until loc_ack.
- loc_wr  in  1  local write (1) / read (0); sampled with loc_req.
- loc_adr  in  ADRSIZE-1  local register index.
- loc_wdata  in  DATASIZE  local write data.
- loc_rdata  out  DATASIZE  local read data; valid in the loc_ack cycle.
- loc_ack  out  1  one-cycle completion pulse.
- reg_adr  out  ADRSIZE-1  bus register index.
- reg_wr  out  1  bus write strobe; level, held until reg_ack.
- reg_rd  out  1  bus read strobe; level, held until reg_ack.
- reg_wdata  out  DATASIZE  bus write data.
- reg_rdata  in  DATASIZE  bus read data; valid when reg_ack=1.
- reg_ack  in  1  bus completion.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky bus-timeout flag; cleared by reset only.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, FSM in IDLE, pending flags and synchronisers cleared.
- CDC:
  - spi_adr_latched and spi_data_latched each pass through a 2-flop synchroniser plus a 3rd flop.
  - A rising edge of the synchronised level sets the pending flag pend_rd or pend_wr respectively.
- Event qualification:
  - pend_rd is set only if spi_adr MSB=0.
  - pend_wr is set only if spi_adr MSB=1.
  - spi_adr and spi_wdata are sampled into local registers in the same cycle the pending flag is set; they are quasi-static, so no synchroniser.
- Falling edges are ignored. The slave clears its flags at the start of the next frame, which re-arms edge detection.
- FSM states: IDLE, SPI_RD, SPI_WR, LOC, DONE.
- IDLE:
  - Priority is pend_rd > pend_wr > loc_req.
  - Enter SPI_RD/SPI_WR (clearing the flag) or LOC.
  - Drive reg_adr, reg_wdata and reg_rd/reg_wr in the next cycle.
- SPI_RD/SPI_WR/LOC:
  - Hold the strobe until reg_ack.
  - On reg_ack, drop the strobe and go to DONE.
  - SPI_RD: capture reg_rdata into spi_rdata.
  - LOC read: capture reg_rdata into loc_rdata and pulse loc_ack.
  - LOC write: pulse loc_ack.
- DONE: one idle bus cycle, then IDLE. Guarantees a strobe de-assertion between accesses.
- Latency:
  - SPI read event: synchroniser edge to reg_rd is 4 clocks.
  - Read data reaches spi_rdata 1 clock after reg_ack.
  - The 8x clock ratio plus one-sclk prefetch margin requires reg_ack within 4 clocks for SPI reads; otherwise the shifted data is stale (documented constraint, not checked).
- Simultaneous events: a SPI event arriving during LOC is held pending and served next. A local request is never pre-empted mid-access.
- Starvation: local may starve only under back-to-back SPI frames; acceptable.
- New event of the same kind while still pending: the flag stays set and the newer address/data overwrite the sampled registers (last frame wins).

Optional Feature:
- Macro: SPI_REG_TIMEOUT_EN.
- Defined:
  - Counter starts on strobe assertion.
  - If it reaches TIMEOUT-1 without reg_ack: drop the strobe, set err, go to DONE.
  - SPI_RD loads ERR_WORD into spi_rdata.
  - LOC pulses loc_ack with loc_rdata=ERR_WORD.
- Undefined: wait indefinitely for reg_ack; err tied 0.

Decomposition:
- Package spi_reg_pkg holds:
  - FSM state enum;
  - ADRSIZE/DATASIZE defaults;
  - the write-flag bit position constant;
  - ERR_WORD.
- Sub-module edge_sync: 3-flop synchroniser with rising-edge pulse output. Instantiated twice.

Test Plan:
- SPI read:
  - Stimulus: spi_adr=8'h05, raise spi_adr_latched; reg_ack 2 clocks after reg_rd with reg_rdata=32'hCAFE0001.
  - Required: reg_adr=7'h05, reg_rd high 4 clocks after the edge, spi_rdata=32'hCAFE0001 1 clock after ack.
- SPI write:
  - Stimulus: spi_adr=8'h83, spi_wdata=32'h12345678, raise spi_data_latched.
  - Required: single reg_wr to 7'h03 with reg_wdata=32'h12345678; no reg_rd issued on the earlier adr_latched edge.
- Contention:
  - Stimulus: loc_req read of 7'h10 and SPI read event in the same IDLE cycle.
  - Required: SPI access first, DONE, then local access; loc_ack single pulse.
- SPI during local:
  - Stimulus: SPI write edge arrives while LOC is awaiting ack.
  - Required: LOC completes; SPI_WR follows with the sampled data.
- Timeout (with SPI_REG_TIMEOUT_EN, TIMEOUT=64):
  - Stimulus: SPI read, reg_ack never asserted.
  - Required: reg_rd drops after 64 clocks, err=1, spi_rdata=32'hDEADBEEF.
- Reset mid-access:
  - Stimulus: reset_n low while reg_wr is high.
  - Required: next edge has all outputs 0 and pending flags cleared; no access after release until a new edge.
